// File: rtl/expr_parser.sv
// expr_parser: reads an ASCII character stream of the form <digits><op><digits>=,
// hands the two operands and the operator to the calculator, and waits for the result.
module expr_parser #(
   parameter int unsigned WAIT_MAX = 16   // legal range 1..255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       calc_done,
   output logic [7:0] operand1,
   output logic [7:0] operand2,
   output logic [7:0] operator,
   output logic       start_calc,
   output logic       busy,
   output logic       err
);

   typedef enum logic [1:0] {
      S_OP1  = 2'd0,
      S_OP2  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

   state_t     state_q, state_d;
   logic [1:0] dcnt_q, dcnt_d;     // digits entered in the current operand
   logic [7:0] wcnt_q, wcnt_d;     // edges spent in S_WAIT without calc_done
   logic [7:0] op1_d, op2_d, oper_d;
   logic       start_d, err_d;

   // Character classes
   logic is_digit, is_op, is_term, is_space, is_clear;
   // Decimal accumulation for the operand currently being entered
   logic [7:0]  acc_base;
   logic [11:0] acc_sum;
   logic [7:0]  acc_sat;

   // Classify the incoming character and compute the saturated next operand value
   always_comb begin
      is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
      is_op    = (rx_data == 8'h2B) || (rx_data == 8'h2D) ||
                 (rx_data == 8'h2A) || (rx_data == 8'h2F);
      is_term  = (rx_data == 8'h3D) || (rx_data == 8'h0D);
      is_space = (rx_data == 8'h20);
      is_clear = (rx_data == 8'h43) || (rx_data == 8'h63);
      // The first digit of an operand always starts from zero, so values left
      // over from a previous expression never leak into the new one.
      if (dcnt_q == 2'd0)
         acc_base = 8'd0;
      else if (state_q == S_OP2)
         acc_base = operand2;
      else
         acc_base = operand1;
      // 12 bits hold 255*10+9 without overflow before the clamp
      acc_sum = ({4'd0, acc_base} * 12'd10) + {8'd0, rx_data[3:0]};
      acc_sat = (acc_sum > 12'd255) ? 8'hFF : acc_sum[7:0];
   end

   // Next-state and next-output logic for the parser FSM
   always_comb begin
      logic do_error;
      // NOTE: every variable gets a default before the case; a path that leaves
      // one unassigned would infer a latch.
      state_d  = state_q;
      dcnt_d   = dcnt_q;
      wcnt_d   = wcnt_q;
      op1_d    = operand1;
      op2_d    = operand2;
      oper_d   = operator;
      start_d  = 1'b0;
      err_d    = 1'b0;
      do_error = 1'b0;

      unique case (state_q)
         S_OP1, S_OP2: begin
            if (rx_valid) begin
               if (is_digit) begin
                  if (dcnt_q == 2'd3) begin
                     do_error = 1'b1;
                  end else begin
                     if (state_q == S_OP1) op1_d = acc_sat;
                     else                  op2_d = acc_sat;
                     dcnt_d = dcnt_q + 2'd1;
                  end
               end else if (is_op) begin
                  if ((state_q == S_OP1) && (dcnt_q != 2'd0)) begin
                     oper_d  = rx_data;
                     dcnt_d  = 2'd0;
                     state_d = S_OP2;
                  end else begin
                     do_error = 1'b1;
                  end
               end else if (is_term) begin
                  if ((state_q == S_OP2) && (dcnt_q != 2'd0)) begin
                     start_d = 1'b1;
                     wcnt_d  = 8'd0;
                     state_d = S_WAIT;
                  end else begin
                     do_error = 1'b1;
                  end
               end else if (is_space) begin
                  // spaces are ignored
               end else if (is_clear) begin
                  op1_d   = 8'd0;
                  op2_d   = 8'd0;
                  oper_d  = 8'd0;
                  dcnt_d  = 2'd0;
                  state_d = S_OP1;
               end else begin
                  do_error = 1'b1;
               end
            end
         end

         S_WAIT: begin
            // Incoming characters are dropped here; calc_done beats the timeout.
            if (calc_done) begin
               dcnt_d  = 2'd0;
               state_d = S_OP1;
            end else if (wcnt_q == WAIT_LAST) begin
               do_error = 1'b1;
            end else begin
               wcnt_d = wcnt_q + 8'd1;
            end
         end

         default: begin
            do_error = 1'b1;
         end
      endcase

      if (do_error) begin
         err_d   = 1'b1;
         op1_d   = 8'd0;
         op2_d   = 8'd0;
         oper_d  = 8'd0;
         dcnt_d  = 2'd0;
         state_d = S_OP1;
      end
   end

   // State and output registers with synchronous active-high reset
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the values from before this edge, independent of statement order.
      if (rst) begin
         state_q    <= S_OP1;
         dcnt_q     <= 2'd0;
         wcnt_q     <= 8'd0;
         operand1   <= 8'd0;
         operand2   <= 8'd0;
         operator   <= 8'd0;
         start_calc <= 1'b0;
         busy       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state_q    <= state_d;
         dcnt_q     <= dcnt_d;
         wcnt_q     <= wcnt_d;
         operand1   <= op1_d;
         operand2   <= op2_d;
         operator   <= oper_d;
         start_calc <= start_d;
         busy       <= (state_d == S_WAIT);
         err        <= err_d;
      end
   end

endmodule

// File: tb/tb_expr_parser.sv
// Directed self-checking bench for expr_parser (WAIT_MAX=4).
module tb_expr_parser;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_data = 8'd0;
   logic       rx_valid = 1'b0;
   logic       calc_done = 1'b0;
   logic [7:0] operand1, operand2, operator;
   logic       start_calc, busy, err;

   int n_checks = 0;
   int n_errors = 0;
   int start_cnt = 0;
   int err_cnt = 0;
   int s0, e0;
   logic [7:0] calc_result;

   expr_parser #(.WAIT_MAX(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .calc_done  (calc_done),
      .operand1   (operand1),
      .operand2   (operand2),
      .operator   (operator),
      .start_calc (start_calc),
      .busy       (busy),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Pulse counters, sampled on the falling edge (each pulse spans one full cycle)
   always @(negedge clk) begin
      if (start_calc) start_cnt++;
      if (err) err_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_ops(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] o);
      check({tag, ".operand1"}, operand1, a);
      check({tag, ".operand2"}, operand2, b);
      check({tag, ".operator"}, operator, o);
   endtask

   // Drive one character for one cycle; returns at the falling edge after it was sampled
   task automatic send(input byte c);
      @(negedge clk);
      rx_data  = c;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic gap();
      @(negedge clk);
   endtask

   // One character every two cycles
   task automatic feed(input string s);
      for (int i = 0; i < s.len(); i++) begin
         send(s[i]);
         gap();
      end
   endtask

   function automatic logic [7:0] calc(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] o);
      case (o)
         8'h2B:   calc = a + b;
         8'h2D:   calc = a - b;
         8'h2A:   calc = a * b;
         8'h2F:   calc = (b == 8'd0) ? 8'd0 : a / b;
         default: calc = 8'd0;
      endcase
   endfunction

   // Calculator stand-in: called right after the terminator edge E; calc_done is sampled at E+2
   task automatic respond(input string tag);
      check({tag, ".start_hi"}, start_calc, 1'b1);
      check({tag, ".busy_hi"}, busy, 1'b1);
      @(negedge clk);
      check({tag, ".start_one_cycle"}, start_calc, 1'b0);
      check({tag, ".busy_held"}, busy, 1'b1);
      calc_result = calc(operand1, operand2, operator);
      calc_done = 1'b1;
      @(negedge clk);
      calc_done = 1'b0;
      check({tag, ".busy_drop"}, busy, 1'b0);
   endtask

   initial begin
      // Reset
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst.operand1", operand1, 8'd0);
      check("rst.operand2", operand2, 8'd0);
      check("rst.operator", operator, 8'd0);
      check("rst.start", start_calc, 1'b0);
      check("rst.busy", busy, 1'b0);
      check("rst.err", err, 1'b0);

      // Basic expression 12+34=
      s0 = start_cnt; e0 = err_cnt;
      send("1"); gap();
      check("basic.op1_1", operand1, 8'd1);
      send("2"); gap();
      check("basic.op1_12", operand1, 8'd12);
      send("+"); gap();
      check("basic.oper", operator, 8'h2B);
      feed("34");
      check("basic.op2_34", operand2, 8'd34);
      send("=");
      check_ops("basic", 8'd12, 8'd34, 8'h2B);
      respond("basic");
      check("basic.result", calc_result, 8'd46);
      check("basic.one_start", start_cnt, s0 + 1);
      check("basic.no_err", err_cnt, e0);

      // Saturation 300*2=
      s0 = start_cnt;
      send("3"); gap();
      check("sat.restart", operand1, 8'd3);
      feed("00");
      check("sat.clamp", operand1, 8'd255);
      feed("*2");
      send("=");
      check_ops("sat", 8'd255, 8'd2, 8'h2A);
      respond("sat");
      check("sat.one_start", start_cnt, s0 + 1);

      // Errors
      s0 = start_cnt; e0 = err_cnt;
      feed("123");
      check("err4.op1_123", operand1, 8'd123);
      send("4");
      check("err4.err", err, 1'b1);
      check("err4.op1_cleared", operand1, 8'd0);
      gap();
      check("err4.err_one_cycle", err, 1'b0);
      send("+");
      check("errop.err", err, 1'b1);
      gap();
      send("5");
      check("errop.digit_ok", err, 1'b0);
      check("errop.op1_5", operand1, 8'd5);
      gap();
      send("=");
      check("errop.term_in_op1", err, 1'b1);
      gap();
      feed("7-");
      check("errterm.oper", operator, 8'h2D);
      send("=");
      check("errterm.err", err, 1'b1);
      check_ops("errterm", 8'd0, 8'd0, 8'd0);
      gap();
      check("err.no_start", start_cnt, s0);
      check("err.count", err_cnt, e0 + 4);

      // Clear and spaces
      s0 = start_cnt; e0 = err_cnt;
      feed("5 / ");
      check("clr.before", operator, 8'h2F);
      send("C"); gap();
      check_ops("clr.after_c", 8'd0, 8'd0, 8'd0);
      feed("8/2");
      send("=");
      check_ops("clr", 8'd8, 8'd2, 8'h2F);
      respond("clr");
      check("clr.no_err", err_cnt, e0);
      check("clr.one_start", start_cnt, s0 + 1);

      // Timeout (calc_done held low) with a character dropped during S_WAIT
      s0 = start_cnt;
      feed("9-3");
      send("=");                      // accepted at edge E
      check("tmo.start", start_calc, 1'b1);
      send("1");                      // sampled at E+2 while busy
      check("tmo.no_err_e2", err, 1'b0);
      check("tmo.busy_e2", busy, 1'b1);
      gap();
      check("tmo.no_err_e3", err, 1'b0);
      gap();
      check("tmo.err_e4", err, 1'b1);
      check("tmo.op1_dropped", operand1, 8'd0);
      check("tmo.busy_low", busy, 1'b0);
      gap();
      check("tmo.err_one_cycle", err, 1'b0);
      check("tmo.one_start", start_cnt, s0 + 1);

      // Reset mid-entry
      s0 = start_cnt;
      feed("45*");
      check("rstmid.oper", operator, 8'h2A);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      check_ops("rstmid", 8'd0, 8'd0, 8'd0);
      check("rstmid.busy", busy, 1'b0);
      check("rstmid.err", err, 1'b0);

      // Reset during S_WAIT
      feed("12+3");
      send("=");
      check("rstwait.start", start_calc, 1'b1);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      check_ops("rstwait", 8'd0, 8'd0, 8'd0);
      check("rstwait.busy", busy, 1'b0);
      check("rstwait.start_low", start_calc, 1'b0);
      check("rstwait.err", err, 1'b0);
      gap();
      check("rstwait.starts", start_cnt, s0 + 1);

      // Parse again after reset
      feed("12+3");
      send("=");
      check_ops("post", 8'd12, 8'd3, 8'h2B);
      respond("post");
      check("post.result", calc_result, 8'd15);
      check("post.starts", start_cnt, s0 + 2);

      repeat (2) gap();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/expr_parser.md
# expr_parser

Upstream front end for the calculator stage. Consumes a byte stream of ASCII characters and parses expressions of the form `<digits><op><digits>=`. On the terminator it drives `operand1`, `operand2` and `operator` to the calculator, pulses `start_calc`, then holds off new input until `calc_done` returns or a timeout expires. Malformed input is reported on a one-cycle `err` pulse, after which the block restarts entry.

## Interface

Parameters:
- `WAIT_MAX`, default 16: cycles to wait for `calc_done` after `start_calc`; legal range 1..255.

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `rx_data`  in  8: ASCII character; sampled only when `rx_valid`=1.
- `rx_valid`  in  1: one-cycle strobe per character.
- `calc_done`  in  1: completion strobe from the calculator.
- `operand1`  out  8: first operand, unsigned decimal value.
- `operand2`  out  8: second operand, unsigned decimal value.
- `operator`  out  8: ASCII operator code: 0x2B `+`, 0x2D `-`, 0x2A `*`, 0x2F `/`.
- `start_calc`  out  1: one-cycle request to the calculator.
- `busy`  out  1: 1 while in S_WAIT; characters are dropped.
- `err`  out  1: one-cycle error pulse.

## Operation

- **Registers:** all outputs are registered.
  - Reset values: `operand1`=0, `operand2`=0, `operator`=0, `start_calc`=0, `busy`=0, `err`=0.
  - Internal reset values: state=S_OP1, digit count=0, wait counter=0.
- **State S_OP1** (entering the first operand):
  - Digit `0`..`9`: `operand1` <= min(`operand1`*10 + d, 255); digit count +1. Compute at 12 bits, then clamp.
  - A 4th digit is an error.
  - Operator `+ - * /` with digit count ≥1: latch `operator`, clear digit count, go to S_OP2.
  - Operator with digit count 0 is an error.
- **State S_OP2** (entering the second operand):
  - Digits accumulate into `operand2` with the same clamp and 3-digit limit.
  - `=` (0x3D) or CR (0x0D) with digit count ≥1: set `start_calc`=1 and `busy`=1, go to S_WAIT.
  - Terminator with digit count 0 is an error.
  - An operator character in S_OP2 is an error.
- **Characters in S_OP1 and S_OP2:**
  - Space (0x20) is ignored.
  - `C` (0x43) or `c` (0x63) clears `operand1`, `operand2`, `operator` and the digit count, returns to S_OP1, and does not raise `err`.
  - Any other character is an error.
- **State S_WAIT:**
  - `start_calc` is cleared after one cycle.
  - `calc_done`=1: clear the digit count, drop `busy`, go to S_OP1. The operand and operator registers hold their last values until the next digit overwrites them; the first new digit restarts from 0.
  - The wait counter increments on each sampled edge without `calc_done`. If no `calc_done` arrives within `WAIT_MAX` edges, raise `err` and go to S_OP1.
  - `rx_valid` is ignored; characters are dropped silently.
- **Error action:**
  - `err`=1 for one cycle.
  - `operand1`, `operand2` and `operator` are cleared to 0.
  - Digit count is cleared.
  - State goes to S_OP1.
- `calc_done` in S_OP1 or S_OP2 is ignored.

## Timing

- A character is sampled at edge K. Its register and state updates are visible after edge K.
- **Terminator accepted at edge E:**
  - `start_calc` is high from E to E+1, exactly one cycle.
  - `operand1`, `operand2` and `operator` are stable from E until S_WAIT exits.
  - `busy` is high from E.
- The calculator responds with `calc_done` sampled at E+2, and the block is back in S_OP1 after E+2. A character is accepted again at E+3.
- **Timeout:** S_WAIT samples edges E+1 .. E+`WAIT_MAX`. If `calc_done`=0 at all of them, `err` is raised at edge E+`WAIT_MAX`.
- **Simultaneous `calc_done` and `rx_valid` in S_WAIT:** `calc_done` wins and the character is dropped.
- **`rst` asserted:** overrides everything on that edge, including mid-entry and mid-wait. All outputs return to their reset values and no `start_calc` is emitted.
- Back-to-back `rx_valid` on consecutive cycles is supported in S_OP1 and S_OP2.

## Test plan

- **Basic expression:** feed `12+34=`, one character every 2 cycles. Require:
  - `operand1`=12, `operand2`=34, `operator`=0x2B.
  - One `start_calc` pulse.
  - With the calculator attached, result=46; `busy` drops 2 cycles after `start_calc`.
- **Saturation:** feed `300*2=`. Require `operand1`=255, `operand2`=2, `operator`=0x2A, one `start_calc`.
- **Errors:**
  - `1234`: `err` pulse on the 4th digit, `operand1`=0.
  - `+5=`: `err` on the `+`.
  - `7-=`: `err` on the `=`.
  - No `start_calc` in any of these cases.
- **Clear and spaces:** feed `5 / C8/2=`. Require:
  - No `err` on the space or the `C`.
  - Final `operand1`=8, `operand2`=2, `operator`=0x2F.
- **Timeout and dropping:** `WAIT_MAX`=4, `calc_done` tied to 0, feed `9-3=`, then `1` during S_WAIT. Require:
  - `err` exactly 4 edges after the `start_calc` edge.
  - The `1` is dropped: `operand1` is 0 after the error.
- **Reset mid-operation:** assert `rst` for one cycle after `45*`, and separately during S_WAIT. Require all outputs return to 0, no `start_calc`, and `12+3=` parses correctly afterwards.
